// File: rtl/iter_muldiv_if.sv
// rtl/iter_muldiv_if.sv - request/result handshake bundle between the EX stage and iter_muldiv
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_div;
  logic             in_signed;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_hi;
  logic [WIDTH-1:0] out_lo;

  modport master (
    output in_valid, in_div, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_hi, out_lo
  );

  modport slave (
    input  in_valid, in_div, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_hi, out_lo
  );
endinterface

// File: rtl/iter_muldiv.sv
// rtl/iter_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit producing HI/LO over WIDTH/BITS_PER_CYCLE cycles
// MULDIV_ZERO_SKIP_EN: skip the ITER phase when either operand is zero
module iter_muldiv #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  iter_muldiv_if.slave bus,
  output logic         busy
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_t;

  state_t             r_state, w_state_nx;
  logic [WIDTH-1:0]   r_a, r_b, r_opd, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_div, r_signed, r_neg_q, r_neg_r;
  logic [CW-1:0]      r_cnt;

  logic               w_accept, w_skip, w_last, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs, w_q_fix, w_r_fix;
  logic [2*WIDTH-1:0] w_acc_it, w_prod_fix;

  // One single-bit step: restoring divide on {rem,quot}, or shift-add multiply on {prod_hi,multiplier}
  function automatic logic [2*WIDTH-1:0] f_step(input logic [2*WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0]   opd,
                                                input logic               div);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] sum;
    sh  = '0;
    sum = '0;
    if (div) begin
      sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      if (sh >= {1'b0, opd}) begin
        sum    = sh - {1'b0, opd};
        f_step = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        f_step = {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
      f_step = {sum, acc[WIDTH-1:1]};
    end
  endfunction

`ifdef MULDIV_ZERO_SKIP_EN
  assign w_skip = (r_a == '0) || (r_b == '0);
`else
  assign w_skip = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.in_valid && !flush;
  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_a_neg  = r_signed && r_a[WIDTH-1];
  assign w_b_neg  = r_signed && r_b[WIDTH-1];
  assign w_a_abs  = w_a_neg ? -r_a : r_a;
  assign w_b_abs  = w_b_neg ? -r_b : r_b;

  assign w_q_fix    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_r_fix    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;

  always_comb begin
    w_acc_it = r_acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_acc_it = f_step(w_acc_it, r_opd, r_div);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nx = S_PREP;
      S_PREP:  w_state_nx = w_skip ? S_FIXUP : S_ITER;
      S_ITER:  if (w_last) w_state_nx = S_FIXUP;
      S_FIXUP: w_state_nx = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (flush) begin
      w_state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_div    <= 1'b0;
      r_signed <= 1'b0;
      r_opd    <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= bus.in_a;
            r_b      <= bus.in_b;
            r_div    <= bus.in_div;
            r_signed <= bus.in_signed;
          end
        end
        S_PREP: begin
          r_opd   <= r_div ? w_b_abs : w_a_abs;
          r_acc   <= w_skip ? '0 : {{WIDTH{1'b0}}, (r_div ? w_a_abs : w_b_abs)};
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_cnt   <= '0;
        end
        S_ITER: begin
          r_acc <= w_acc_it;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        S_FIXUP: begin
          // Divide-by-zero returns the raw dividend in HI regardless of signedness
          if (!flush) begin
            if (r_div && (r_b == '0)) begin
              r_hi <= r_a;
              r_lo <= '1;
            end else if (r_div) begin
              r_hi <= w_r_fix;
              r_lo <= w_q_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_hi    = r_hi;
  assign bus.out_lo    = r_lo;
  assign busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_iter_muldiv.sv
// tb/tb_iter_muldiv.sv - randomized self-checking bench for iter_muldiv at 1, 2 and 4 bits per cycle
module tb_iter_muldiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [2:0]       t_in_valid, t_in_div, t_in_signed, t_out_ready, t_flush;
  logic [2:0][31:0] t_in_a, t_in_b;
  logic [2:0]       t_in_ready, t_out_valid, t_busy;
  logic [2:0][31:0] t_out_hi, t_out_lo;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MULDIV_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // Instance g retires 2**g bits per cycle
  for (genvar g = 0; g < 3; g++) begin : g_dut
    iter_muldiv_if #(.WIDTH(32)) bus ();
    assign bus.in_valid    = t_in_valid[g];
    assign bus.in_div      = t_in_div[g];
    assign bus.in_signed   = t_in_signed[g];
    assign bus.in_a        = t_in_a[g];
    assign bus.in_b        = t_in_b[g];
    assign bus.out_ready   = t_out_ready[g];
    assign t_in_ready[g]   = bus.in_ready;
    assign t_out_valid[g]  = bus.out_valid;
    assign t_out_hi[g]     = bus.out_hi;
    assign t_out_lo[g]     = bus.out_lo;
    iter_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(1 << g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (t_flush[g]),
      .bus   (bus),
      .busy  (t_busy[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic div, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     q, r;
    if (!div) begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return sa * sb;
      end
      return {32'b0, a} * {32'b0, b};
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  function automatic int exp_lat(input int d, input logic [31:0] a, input logic [31:0] b);
    if (SKIP && (a == 32'h0 || b == 32'h0)) return 2;
    return 32 / (1 << d) + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input int d, input logic div, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input string tag);
    logic [63:0] exp;
    int          lat, w;
    exp = ref_op(div, sgn, a, b);
    @(negedge clk);
    w = 0;
    while (!t_in_ready[d] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, "/ready"}, t_in_ready[d], 1);
    t_in_valid[d]  = 1'b1;
    t_in_div[d]    = div;
    t_in_signed[d] = sgn;
    t_in_a[d]      = a;
    t_in_b[d]      = b;
    t_out_ready[d] = 1'b0;
    @(posedge clk);
    #1;
    t_in_valid[d]  = 1'b0;
    t_in_a[d]      = $urandom;
    t_in_b[d]      = $urandom;
    t_in_div[d]    = 1'($urandom_range(0, 1));
    t_in_signed[d] = 1'($urandom_range(0, 1));
    lat = 0;
    while (!t_out_valid[d] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/lat"}, 64'(lat), 64'(exp_lat(d, a, b)));
    check({tag, "/hilo"}, {t_out_hi[d], t_out_lo[d]}, exp);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check({tag, "/hold_ctl"}, {t_out_valid[d], t_in_ready[d], t_busy[d]}, 3'b101);
      check({tag, "/hold_data"}, {t_out_hi[d], t_out_lo[d]}, exp);
    end
    t_out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    t_out_ready[d] = 1'b0;
    check({tag, "/post_hs"}, {t_in_ready[d], t_out_valid[d]}, 2'b10);
  endtask

  logic seen;

  initial begin
    t_in_valid = '0; t_in_div = '0; t_in_signed = '0; t_out_ready = '0; t_flush = '0;
    t_in_a = '0; t_in_b = '0;
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 3; d++) begin
      check("reset/ctl", {t_in_ready[d], t_out_valid[d], t_busy[d]}, 3'b100);
      check("reset/data", {t_out_hi[d], t_out_lo[d]}, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 3; d++) begin
      run_op(d, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "t1/umul_max");
      check("t1/const", {t_out_hi[d], t_out_lo[d]}, 64'hFFFF_FFFE_0000_0001);
      run_op(d, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, "t2/sdiv_m7_2");
      check("t2/const", {t_out_hi[d], t_out_lo[d]}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(d, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "t2/sdiv_ovf");
      check("t2/ovf_const", {t_out_hi[d], t_out_lo[d]}, 64'h0000_0000_8000_0000);
    end

    run_op(0, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 0, "t3/udiv0");
    check("t3/const", {t_out_hi[0], t_out_lo[0]}, 64'h1234_5678_FFFF_FFFF);
    run_op(0, 1'b1, 1'b1, 32'h1234_5678, 32'h0, 0, "t3/sdiv0");

    run_op(0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 10, "t4/backpressure");
    run_op(0, 1'b1, 1'b0, 32'd100, 32'd7, 0, "t4/back_to_back");

    @(negedge clk);
    t_in_valid[0] = 1'b1; t_in_div[0] = 1'b0; t_in_signed[0] = 1'b1;
    t_in_a[0] = 32'hFFFF_FFFD; t_in_b[0] = 32'd5;
    @(posedge clk);
    #1;
    t_in_valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t5/busy_before", t_busy[0], 1);
    t_flush[0] = 1'b1;
    @(posedge clk);
    #1;
    t_flush[0] = 1'b0;
    check("t5/idle_after", {t_busy[0], t_in_ready[0], t_out_valid[0]}, 3'b010);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen = seen | t_out_valid[0];
    end
    check("t5/no_valid", seen, 0);
    @(negedge clk);
    t_flush[0] = 1'b1; t_in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    t_flush[0] = 1'b0; t_in_valid[0] = 1'b0;
    check("t5/flush_blocks_accept", t_busy[0], 0);
    run_op(0, 1'b0, 1'b1, 32'd6, 32'd7, 0, "t5/6x7");
    check("t5/const", {t_out_hi[0], t_out_lo[0]}, 64'd42);

    @(negedge clk);
    t_in_valid[0] = 1'b1; t_in_div[0] = 1'b1; t_in_signed[0] = 1'b0;
    t_in_a[0] = 32'd1000; t_in_b[0] = 32'd7;
    @(posedge clk);
    #1;
    t_in_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6/async_ctl", {t_in_ready[0], t_out_valid[0], t_busy[0]}, 3'b100);
    check("t6/async_data", {t_out_hi[0], t_out_lo[0]}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen = seen | t_out_valid[0];
    end
    check("t6/no_output", seen, 0);

    for (int i = 0; i < 60; i++) begin
      run_op($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             pick(), pick(), $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
